// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_sequencer
// Description : Drives the PC and IF/ID/EXE/MEM stage-register enables and
//               bubble flushes. It provides a startup fill ramp, load-use
//               bubble insertion, taken-branch flush and an optional
//               fixed-latency mul/div freeze.
// Options     : PIPE_MD_STALL_EN - when defined, adds the MD_WAIT state,
//               md_cnt and the id_md_start handling.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_sequencer #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_CYCLES  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  id_md_start,
    input  logic                  exe_is_load,
    input  logic                  exe_rd_we,
    input  logic [REG_ADDR_W-1:0] exe_rd_addr,
    input  logic                  exe_branch_taken,
    output logic                  pc_ena,
    output logic                  if_id_ena,
    output logic                  id_exe_ena,
    output logic                  exe_mem_ena,
    output logic                  if_id_flush,
    output logic                  id_exe_flush,
    output logic                  md_busy,
    output logic [1:0]            seq_state
);

    localparam logic [1:0] c_ST_FILL    = 2'b00;
    localparam logic [1:0] c_ST_RUN     = 2'b01;
    localparam logic [1:0] c_ST_MD_WAIT = 2'b10;

    logic [1:0] state_q, state_d;
    logic [1:0] fill_cnt_q, fill_cnt_d;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_use;

    logic w_pc_ena;
    logic w_if_id_ena;
    logic w_id_exe_ena;
    logic w_exe_mem_ena;
    logic w_if_id_flush;
    logic w_id_exe_flush;

`ifdef PIPE_MD_STALL_EN
    localparam int                c_MD_W    = $clog2(MD_CYCLES);
    // The start cycle counts as one EXE cycle, and the cycle that sees
    // md_cnt==0 is the last MD_WAIT cycle, hence the -2 preload.
    localparam logic [c_MD_W-1:0] c_MD_LOAD = c_MD_W'(MD_CYCLES - 2);
    localparam logic [c_MD_W-1:0] c_MD_ONE  = c_MD_W'(1);

    logic [c_MD_W-1:0] md_cnt_q, md_cnt_d;
`else
    // Mul/div freeze is compiled out; the start strobe has no effect.
    logic w_unused_md_start;
    assign w_unused_md_start = id_md_start;
`endif

    // Load-use: the ID instruction needs a register a load in EXE has not produced yet.
    assign w_rs_hit   = id_rs_used && (id_rs_addr == exe_rd_addr);
    assign w_rt_hit   = id_rt_used && (id_rt_addr == exe_rd_addr);
    assign w_load_use = exe_is_load && exe_rd_we && (exe_rd_addr != '0) && (w_rs_hit || w_rt_hit);

    // State register: reset restarts the fill ramp from any phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= c_ST_FILL;
            fill_cnt_q <= 2'd0;
`ifdef PIPE_MD_STALL_EN
            md_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
`ifdef PIPE_MD_STALL_EN
            md_cnt_q   <= md_cnt_d;
`endif
        end
    end

    // Next-state logic: everything holds while ena is low.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
`ifdef PIPE_MD_STALL_EN
        md_cnt_d   = md_cnt_q;
`endif
        if (ena) begin
            case (state_q)
                c_ST_FILL: begin
                    if (fill_cnt_q == 2'd2) begin
                        state_d = c_ST_RUN;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 2'd1;
                    end
                end
                c_ST_RUN: begin
`ifdef PIPE_MD_STALL_EN
                    // A branch squashes the mul/div; a load-use stall defers it.
                    if (!exe_branch_taken && !w_load_use && id_md_start) begin
                        state_d  = c_ST_MD_WAIT;
                        md_cnt_d = c_MD_LOAD;
                    end
`else
                    state_d = c_ST_RUN;
`endif
                end
`ifdef PIPE_MD_STALL_EN
                c_ST_MD_WAIT: begin
                    if (md_cnt_q == '0) begin
                        state_d = c_ST_RUN;
                    end else begin
                        md_cnt_d = md_cnt_q - c_MD_ONE;
                    end
                end
`endif
                default: state_d = c_ST_FILL;
            endcase
        end
    end

    // Output decode before the global run-enable gate.
    always_comb begin
        w_pc_ena       = 1'b0;
        w_if_id_ena    = 1'b0;
        w_id_exe_ena   = 1'b0;
        w_exe_mem_ena  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_exe_flush = 1'b0;
        case (state_q)
            c_ST_FILL: begin
                w_pc_ena     = 1'b1;
                w_if_id_ena  = (fill_cnt_q >= 2'd1);
                w_id_exe_ena = (fill_cnt_q >= 2'd2);
            end
            c_ST_RUN: begin
                if (exe_branch_taken) begin
                    w_pc_ena       = 1'b1;
                    w_if_id_ena    = 1'b1;
                    w_id_exe_ena   = 1'b1;
                    w_exe_mem_ena  = 1'b1;
                    w_if_id_flush  = 1'b1;
                    w_id_exe_flush = 1'b1;
                end else if (w_load_use) begin
                    // Hold PC and IF/ID, push a bubble into EXE, let the load drain.
                    w_id_exe_ena   = 1'b1;
                    w_id_exe_flush = 1'b1;
                    w_exe_mem_ena  = 1'b1;
                end else begin
                    w_pc_ena      = 1'b1;
                    w_if_id_ena   = 1'b1;
                    w_id_exe_ena  = 1'b1;
                    w_exe_mem_ena = 1'b1;
                end
            end
            c_ST_MD_WAIT: begin
                w_pc_ena = 1'b0;
            end
            default: begin
                w_pc_ena = 1'b0;
            end
        endcase
    end

    assign pc_ena       = ena && w_pc_ena;
    assign if_id_ena    = ena && w_if_id_ena;
    assign id_exe_ena   = ena && w_id_exe_ena;
    assign exe_mem_ena  = ena && w_exe_mem_ena;
    assign if_id_flush  = ena && w_if_id_flush;
    assign id_exe_flush = ena && w_id_exe_flush;
    assign seq_state    = state_q;

`ifdef PIPE_MD_STALL_EN
    assign md_busy = (state_q == c_ST_MD_WAIT);
`else
    assign md_busy = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_sequencer
// Description : Self-checking bench for pipeline_sequencer (MD_CYCLES=4).
//               Directed scenarios with literal expectations, then random
//               traffic compared every cycle against a phase-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_sequencer;

    localparam int REG_ADDR_W = 5;
    localparam int MD_CYCLES  = 4;
`ifdef PIPE_MD_STALL_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic                  clk;
    logic                  reset;
    logic                  ena;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic                  id_md_start;
    logic                  exe_is_load;
    logic                  exe_rd_we;
    logic [REG_ADDR_W-1:0] exe_rd_addr;
    logic                  exe_branch_taken;
    logic                  pc_ena;
    logic                  if_id_ena;
    logic                  id_exe_ena;
    logic                  exe_mem_ena;
    logic                  if_id_flush;
    logic                  id_exe_flush;
    logic                  md_busy;
    logic [1:0]            seq_state;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_sequencer #(
        .REG_ADDR_W (REG_ADDR_W),
        .MD_CYCLES  (MD_CYCLES)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .ena              (ena),
        .id_rs_addr       (id_rs_addr),
        .id_rt_addr       (id_rt_addr),
        .id_rs_used       (id_rs_used),
        .id_rt_used       (id_rt_used),
        .id_md_start      (id_md_start),
        .exe_is_load      (exe_is_load),
        .exe_rd_we        (exe_rd_we),
        .exe_rd_addr      (exe_rd_addr),
        .exe_branch_taken (exe_branch_taken),
        .pc_ena           (pc_ena),
        .if_id_ena        (if_id_ena),
        .id_exe_ena       (id_exe_ena),
        .exe_mem_ena      (exe_mem_ena),
        .if_id_flush      (if_id_flush),
        .id_exe_flush     (id_exe_flush),
        .md_busy          (md_busy),
        .seq_state        (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Step to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs_addr = '0; id_rt_addr = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_md_start = 1'b0; exe_is_load = 1'b0; exe_rd_we = 1'b0;
        exe_rd_addr = '0; exe_branch_taken = 1'b0;
    endtask

    function automatic logic [3:0] ens();
        return {pc_ena, if_id_ena, id_exe_ena, exe_mem_ena};
    endfunction

    // ------------------------------------------------------------------
    // Phase-level model: FILL lasts 3 enabled cycles after reset, then
    // RUN; an accepted mul/div start buys MD_CYCLES-1 enabled MD_WAIT cycles.
    // ------------------------------------------------------------------
    bit m_valid   = 1'b0;
    int m_since   = 0;
    int m_md_rem  = 0;

    always @(negedge clk) begin
        logic       lu;
        logic [8:0] exp_v;
        logic [8:0] act_v;
        int         phase;   // 0 fill, 1 run, 2 mul/div wait
        lu = exe_is_load && exe_rd_we && (exe_rd_addr != 0) &&
             ((id_rs_used && id_rs_addr == exe_rd_addr) ||
              (id_rt_used && id_rt_addr == exe_rd_addr));
        phase = (m_since < 3) ? 0 : ((m_md_rem > 0) ? 2 : 1);
        if (m_valid) begin
            // vector: state[8:7] busy[6] pc ifid idexe exemem ifflush idflush
            exp_v = '0;
            if (phase == 0) begin
                exp_v[8:7] = 2'b00;
                exp_v[5]   = ena;
                exp_v[4]   = ena && (m_since >= 1);
                exp_v[3]   = ena && (m_since >= 2);
            end else if (phase == 2) begin
                exp_v[8:7] = 2'b10;
                exp_v[6]   = 1'b1;
            end else begin
                exp_v[8:7] = 2'b01;
                if (exe_branch_taken) begin
                    exp_v[5:0] = {6{ena}};
                end else if (lu) begin
                    exp_v[3] = ena; exp_v[2] = ena; exp_v[0] = ena;
                end else begin
                    exp_v[5:2] = {4{ena}};
                end
            end
            act_v = {seq_state, md_busy, pc_ena, if_id_ena, id_exe_ena, exe_mem_ena,
                     if_id_flush, id_exe_flush};
            chk("model_outputs", {23'd0, act_v}, {23'd0, exp_v});
        end
        if (reset) begin
            m_valid  = 1'b1;
            m_since  = 0;
            m_md_rem = 0;
        end else if (m_valid && ena) begin
            if (phase == 0) m_since++;
            else if (phase == 2) m_md_rem--;
            else if (MD_EN && !exe_branch_taken && !lu && id_md_start) m_md_rem = MD_CYCLES - 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with literal expectations, then randomized traffic.
    // ------------------------------------------------------------------
    initial begin
        int md_count;
        logic [1:0] mdst;
        mdst = MD_EN ? 2'b10 : 2'b01;
        reset = 1'b1;
        ena   = 1'b1;
        idle_inputs();

        // Reset: FILL with only PC enabled.
        step();
        @(negedge clk);
        chk("reset_state", seq_state, 2'b00);
        chk("reset_enables", ens(), 4'b1000);
        chk("reset_busy", md_busy, 1'b0);
        step();
        reset = 1'b0;

        // Fill ramp: 00,00,00,01 with enables switching on one stage per cycle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fill_state", seq_state, (i < 3) ? 2'b00 : 2'b01);
            chk("fill_enables", ens(), (i == 0) ? 4'b1000 : (i == 1) ? 4'b1100 :
                                       (i == 2) ? 4'b1110 : 4'b1111);
            step();
        end

        // Load-use on rs=8.
        exe_is_load = 1'b1; exe_rd_we = 1'b1; exe_rd_addr = 5'd8;
        id_rs_used = 1'b1; id_rs_addr = 5'd8;
        @(negedge clk);
        chk("lu_enables", ens(), 4'b0011);
        chk("lu_flush", {if_id_flush, id_exe_flush}, 2'b01);
        step();
        // Same stimulus against r0 is not a hazard.
        exe_rd_addr = 5'd0; id_rs_addr = 5'd0;
        @(negedge clk);
        chk("r0_enables", ens(), 4'b1111);
        chk("r0_flush", {if_id_flush, id_exe_flush}, 2'b00);
        step();

        // Branch outranks load-use and mul/div start.
        exe_rd_addr = 5'd8; id_rs_addr = 5'd8; id_md_start = 1'b1; exe_branch_taken = 1'b1;
        @(negedge clk);
        chk("br_enables", ens(), 4'b1111);
        chk("br_flush", {if_id_flush, id_exe_flush}, 2'b11);
        step();
        idle_inputs();
        @(negedge clk);
        chk("br_next_state", seq_state, 2'b01);
        chk("br_next_busy", md_busy, 1'b0);
        step();

        // Mul/div: start cycle then MD_CYCLES-1 frozen cycles.
        id_md_start = 1'b1;
        @(negedge clk);
        chk("md_start_enables", ens(), 4'b1111);
        step();
        id_md_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("md_state", seq_state, (i < 3) ? mdst : 2'b01);
            chk("md_busy", md_busy, MD_EN && (i < 3));
            chk("md_enables", ens(), (MD_EN && i < 3) ? 4'b0000 : 4'b1111);
            step();
        end

        // Two ena=0 cycles stretch the freeze to 5 cycles.
        id_md_start = 1'b1;
        step();
        id_md_start = 1'b0;
        md_count = 0;
        for (int i = 0; i < 12; i++) begin
            ena = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (seq_state == 2'b10) md_count++;
            step();
        end
        ena = 1'b1;
        chk("md_stretch_len", md_count, MD_EN ? 5 : 0);

        // Reset in the second MD_WAIT cycle restarts the fill ramp.
        id_md_start = 1'b1;
        step();
        id_md_start = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("mdrst_before", seq_state, mdst);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mdrst_fill_state", seq_state, (i < 3) ? 2'b00 : 2'b01);
            if (i == 0) chk("mdrst_busy", md_busy, 1'b0);
            step();
        end

        // Randomized traffic, small register space so hazards occur often.
        for (int i = 0; i < 3000; i++) begin
            reset            = ($urandom_range(0, 99) == 0);
            ena              = ($urandom_range(0, 9) != 0);
            id_rs_addr       = REG_ADDR_W'($urandom_range(0, 3));
            id_rt_addr       = REG_ADDR_W'($urandom_range(0, 3));
            exe_rd_addr      = REG_ADDR_W'($urandom_range(0, 3));
            id_rs_used       = $urandom_range(0, 1) != 0;
            id_rt_used       = $urandom_range(0, 1) != 0;
            exe_is_load      = $urandom_range(0, 2) == 0;
            exe_rd_we        = $urandom_range(0, 3) != 0;
            id_md_start      = $urandom_range(0, 9) == 0;
            exe_branch_taken = $urandom_range(0, 6) == 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
